// File: rtl/game_pkg.sv
// Shared widths, action codes and FSM state encoding for the CPU opponent.
package game_pkg;

  localparam int POS_W    = 3;
  localparam int HEALTH_W = 2;
  localparam int ACT_W    = 3;

  localparam logic [ACT_W-1:0] ACT_LEFT  = 3'b000;
  localparam logic [ACT_W-1:0] ACT_RIGHT = 3'b001;
  localparam logic [ACT_W-1:0] ACT_JUMP  = 3'b010;
  localparam logic [ACT_W-1:0] ACT_WAIT  = 3'b011;
  localparam logic [ACT_W-1:0] ACT_PUNCH = 3'b100;
  localparam logic [ACT_W-1:0] ACT_KICK  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPROACH = 3'd1,
    ST_ATTACK   = 3'd2,
    ST_EVADE    = 3'd3,
    ST_DEFEATED = 3'd4
  } state_e;

  // Cooldown never wraps below zero.
  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

endpackage

// File: rtl/cpu_lfsr8.sv
// 8-bit Fibonacci LFSR; exposes the two low bits used for decisions.
module cpu_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [1:0] bits_o
);

  // An all-zero seed would lock up the register.
  localparam logic [7:0] SEED_C = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Feedback taps 7,5,4,3; advance only when enabled.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_C;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bits_o = lfsr_q[1:0];

endmodule

// File: rtl/cpu_opponent_controller.sv
// CPU player: one registered action decision per game tick, driven by an FSM,
// an attack cooldown and an LFSR choosing punch vs kick.
module cpu_opponent_controller
  import game_pkg::*;
#(
  parameter int unsigned ATTACK_RANGE = 1,
  parameter int unsigned COOLDOWN     = 2,
  parameter logic [7:0]  SEED         = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [POS_W-1:0]    position_self,
  input  logic [POS_W-1:0]    position_opp,
  input  logic [HEALTH_W-1:0] health_self,
  input  logic [HEALTH_W-1:0] health_opp,
  output logic [ACT_W-1:0]    action,
  output logic                action_valid,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] RANGE_C = ATTACK_RANGE[2:0];
  localparam logic [2:0] CD_C    = COOLDOWN[2:0];

  state_e           state_q, state_d;
  logic [ACT_W-1:0] action_q, action_d;
  logic             valid_q, valid_d;
  logic [2:0]       cooldown_q, cooldown_d;
  logic [1:0]       lfsr_bits_s;
  logic [2:0]       dist_s;
  logic [ACT_W-1:0] toward_s, away_s;
  logic             away_blocked_s;

  cpu_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (tick),
    .bits_o (lfsr_bits_s)
  );

  assign dist_s   = (position_self >= position_opp) ? (position_self - position_opp)
                                                    : (position_opp - position_self);
  assign toward_s = (position_opp > position_self) ? ACT_RIGHT : ACT_LEFT;
  assign away_s   = (toward_s == ACT_RIGHT) ? ACT_LEFT : ACT_RIGHT;
  assign away_blocked_s = ((position_self == 3'd0) && (away_s == ACT_LEFT)) ||
                          ((position_self == 3'd7) && (away_s == ACT_RIGHT));

  // Decision priority: defeat, approach, attack, evade.
  always_comb begin
    state_d    = state_q;
    action_d   = action_q;
    cooldown_d = cooldown_q;
    valid_d    = tick;
    if (tick) begin
      if ((state_q == ST_DEFEATED) || (health_self == 2'd0) || (health_opp == 2'd0)) begin
        state_d  = ST_DEFEATED;
        action_d = ACT_WAIT;
      end else if (dist_s > RANGE_C) begin
        state_d    = ST_APPROACH;
        action_d   = toward_s;
        cooldown_d = dec_sat(cooldown_q);
      end else if (cooldown_q == 3'd0) begin
        state_d    = ST_ATTACK;
        action_d   = lfsr_bits_s[0] ? ACT_KICK : ACT_PUNCH;
        cooldown_d = CD_C;
      end else begin
        state_d    = ST_EVADE;
        cooldown_d = dec_sat(cooldown_q);
        if (health_self == 2'd1) begin
          action_d = (away_blocked_s || (dist_s == 3'd0)) ? ACT_JUMP : away_s;
        end else begin
          action_d = lfsr_bits_s[1] ? ACT_JUMP : ACT_WAIT;
        end
      end
    end else begin
      state_d    = state_q;
      action_d   = action_q;
      cooldown_d = cooldown_q;
    end
  end

  // State, action and cooldown registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      action_q   <= ACT_WAIT;
      valid_q    <= 1'b0;
      cooldown_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      action_q   <= action_d;
      valid_q    <= valid_d;
      cooldown_q <= cooldown_d;
    end
  end

  assign action       = action_q;
  assign action_valid = valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_cpu_opponent_controller.sv
// Directed bench for cpu_opponent_controller; a second instance uses SEED 8'hA4.
module tb_cpu_opponent_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] position_self = 3'd0;
  logic [2:0] position_opp = 3'd0;
  logic [1:0] health_self = 2'd3;
  logic [1:0] health_opp = 2'd3;
  logic [2:0] action, action_b;
  logic       action_valid, action_valid_b;
  logic [2:0] state_dbg, state_dbg_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_opponent_controller #(.ATTACK_RANGE(1), .COOLDOWN(2), .SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .position_self(position_self), .position_opp(position_opp),
    .health_self(health_self), .health_opp(health_opp),
    .action(action), .action_valid(action_valid), .state_dbg(state_dbg)
  );

  cpu_opponent_controller #(.ATTACK_RANGE(1), .COOLDOWN(2), .SEED(8'hA4)) dut_b (
    .clk(clk), .reset(reset), .tick(tick),
    .position_self(position_self), .position_opp(position_opp),
    .health_self(health_self), .health_opp(health_opp),
    .action(action_b), .action_valid(action_valid_b), .state_dbg(state_dbg_b)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Pulses tick for one cycle; returns at the negedge where the result is visible.
  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick = 1'b1;
    position_self = 3'd6; position_opp = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (action_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", action_valid); end
      total++;
      if (action !== 3'b011) begin bad++; $display("FAIL rst_action got=%b exp=011", action); end
      total++;
      if (state_dbg !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    end
    tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_approach();
    apply_reset();
    position_self = 3'd6; position_opp = 3'd1; health_self = 2'd3; health_opp = 2'd3;
    do_tick();
    total++;
    if (action !== 3'b000 || action_valid !== 1'b1 || state_dbg !== 3'd1) begin
      bad++; $display("FAIL appr_left got=%b/%b/%0d exp=000/1/1", action, action_valid, state_dbg);
    end
    // Input changes without a tick must not affect the held action.
    position_self = 3'd1; position_opp = 3'd6;
    @(negedge clk);
    total++;
    if (action_valid !== 1'b0 || action !== 3'b000) begin
      bad++; $display("FAIL appr_hold got=%b/%b exp=000/0", action, action_valid);
    end
    do_tick();
    total++;
    if (action !== 3'b001 || state_dbg !== 3'd1) begin
      bad++; $display("FAIL appr_right got=%b/%0d exp=001/1", action, state_dbg);
    end
  endtask

  task automatic test_attack_cooldown();
    apply_reset();
    position_self = 3'd2; position_opp = 3'd1; health_self = 2'd3; health_opp = 2'd3;
    do_tick();
    total++;
    if (action !== 3'b101 || state_dbg !== 3'd2) begin
      bad++; $display("FAIL atk_t1 got=%b/%0d exp=101/2", action, state_dbg);
    end
    total++;
    if (action_b !== 3'b100 || state_dbg_b !== 3'd2) begin
      bad++; $display("FAIL atk_seed_a4 got=%b/%0d exp=100/2", action_b, state_dbg_b);
    end
    do_tick();
    total++;
    if (action !== 3'b010 || state_dbg !== 3'd3) begin
      bad++; $display("FAIL atk_t2 got=%b/%0d exp=010/3", action, state_dbg);
    end
    do_tick();
    total++;
    if (action !== 3'b011 || state_dbg !== 3'd3) begin
      bad++; $display("FAIL atk_t3 got=%b/%0d exp=011/3", action, state_dbg);
    end
    do_tick();
    total++;
    if (action !== 3'b100 || state_dbg !== 3'd2) begin
      bad++; $display("FAIL atk_t4 got=%b/%0d exp=100/2", action, state_dbg);
    end
  endtask

  task automatic test_evade_low_health();
    apply_reset();
    position_self = 3'd2; position_opp = 3'd1; health_self = 2'd3; health_opp = 2'd3;
    do_tick();
    health_self = 2'd1;
    position_self = 3'd3; position_opp = 3'd2;
    do_tick();
    total++;
    if (action !== 3'b001 || state_dbg !== 3'd3) begin
      bad++; $display("FAIL evade_away got=%b/%0d exp=001/3", action, state_dbg);
    end
    position_self = 3'd7; position_opp = 3'd6;
    do_tick();
    total++;
    if (action !== 3'b010 || state_dbg !== 3'd3) begin
      bad++; $display("FAIL evade_edge got=%b/%0d exp=010/3", action, state_dbg);
    end
    do_tick();
    total++;
    if (action !== 3'b100 || state_dbg !== 3'd2) begin
      bad++; $display("FAIL evade_reattack got=%b/%0d exp=100/2", action, state_dbg);
    end
    position_self = 3'd4; position_opp = 3'd4;
    do_tick();
    total++;
    if (action !== 3'b010 || state_dbg !== 3'd3) begin
      bad++; $display("FAIL evade_dist0 got=%b/%0d exp=010/3", action, state_dbg);
    end
    health_self = 2'd3;
  endtask

  task automatic test_defeat();
    apply_reset();
    position_self = 3'd2; position_opp = 3'd1; health_opp = 2'd0;
    do_tick();
    total++;
    if (action !== 3'b011 || state_dbg !== 3'd4 || action_valid !== 1'b1) begin
      bad++; $display("FAIL defeat_enter got=%b/%0d/%b exp=011/4/1", action, state_dbg, action_valid);
    end
    health_opp = 2'd3; position_self = 3'd6; position_opp = 3'd1;
    do_tick();
    total++;
    if (action !== 3'b011 || state_dbg !== 3'd4 || action_valid !== 1'b1) begin
      bad++; $display("FAIL defeat_stay got=%b/%0d/%b exp=011/4/1", action, state_dbg, action_valid);
    end
    apply_reset();
    total++;
    if (state_dbg !== 3'd0 || action !== 3'b011) begin
      bad++; $display("FAIL defeat_reset got=%b/%0d exp=011/0", action, state_dbg);
    end
  endtask

  task automatic test_midop_reset();
    apply_reset();
    position_self = 3'd2; position_opp = 3'd1; health_self = 2'd3; health_opp = 2'd3;
    do_tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (action !== 3'b011 || action_valid !== 1'b0 || state_dbg !== 3'd0) begin
      bad++; $display("FAIL midrst_async got=%b/%b/%0d exp=011/0/0", action, action_valid, state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    do_tick();
    total++;
    if (action !== 3'b101 || state_dbg !== 3'd2) begin
      bad++; $display("FAIL midrst_attack got=%b/%0d exp=101/2", action, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_approach();
    test_attack_cooldown();
    test_evade_low_health();
    test_defeat();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_opponent_controller.md
Name: cpu_opponent_controller

Overview:
Computer-controlled player that drives one action input of two_player_game. It reads the game's health and position outputs and produces one 3-bit action code per game tick. It sits between the game core's status outputs and its action_player2 input, and replaces the human or bench driver. Decisions come from a small FSM with an attack cooldown counter and an LFSR that picks the attack type.

Parameters:
ATTACK_RANGE, 1, max |position difference| at which attacks are issued (0..7)
COOLDOWN, 2, ticks after an attack before the next attack is allowed (0..7)
SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tick  input  1  one-cycle game-step strobe; one decision per tick
position_self  input  3  this player's position (0..7)
position_opp  input  3  opponent's position (0..7)
health_self  input  2  this player's health (0..3)
health_opp  input  2  opponent's health (0..3)
action  output  3  action code to the game
action_valid  output  1  one-cycle pulse, the cycle after tick
state_dbg  output  3  current FSM state encoding

Behaviour:
- Action codes: 000 LEFT, 001 RIGHT, 010 JUMP, 011 WAIT, 100 PUNCH, 101 KICK. Codes 110 and 111 are never driven.
- Reset (reset=0, asynchronous):
  - action=011, action_valid=0, state=IDLE.
  - cooldown counter=0, lfsr=SEED.
  - tick is ignored while reset is low.
- All state updates happen only on a clk edge with tick=1.
  - action is registered and holds between ticks.
  - action_valid=1 for exactly the cycle after a tick.
  - Latency is 1 cycle from tick.
- Derived values:
  - dist = |position_self - position_opp|, 3-bit unsigned.
  - toward = RIGHT if position_opp > position_self, otherwise LEFT.
  - away = the opposite of toward.
- Decision priority, evaluated at each tick:
  1. health_self==0 or health_opp==0 -> state DEFEATED, action WAIT. DEFEATED is terminal until reset; later ticks still pulse action_valid with WAIT.
  2. dist > ATTACK_RANGE -> APPROACH, action=toward. The cooldown counter decrements if nonzero.
  3. dist <= ATTACK_RANGE and cooldown==0 -> ATTACK.
     - action = PUNCH if lfsr[0]==0, otherwise KICK.
     - cooldown loads COOLDOWN.
  4. dist <= ATTACK_RANGE and cooldown>0 -> EVADE; cooldown decrements.
     - If health_self==1: action=away. If away would leave 0..7 (self=0 and away=LEFT, or self=7 and away=RIGHT), or dist==0, action=JUMP instead.
     - Otherwise: action = JUMP if lfsr[1]==1, otherwise WAIT.
- State encoding: IDLE=0, APPROACH=1, ATTACK=2, EVADE=3, DEFEATED=4. IDLE exists only after reset, before the first tick.
- LFSR:
  - 8-bit Fibonacci; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances on every tick, including in DEFEATED.
  - Decisions use the pre-advance value.
- Cooldown arithmetic: saturates at 0 and never wraps. COOLDOWN=0 allows an attack on every in-range tick.
- Inputs are sampled only at tick. Changes between ticks have no effect.

Decomposition:
- Shared package game_pkg:
  - action code constants (ACT_LEFT .. ACT_KICK)
  - FSM state typedef/constants
  - widths: POS_W=3, HEALTH_W=2, ACT_W=3
- One sub-module, cpu_lfsr8: 8-bit LFSR with seed parameter, advance enable, async active-low reset.

Test Plan:
1. Reset check: assert reset=0 with clk running -> action=011, action_valid=0, state_dbg=0. Ticks during reset produce no action_valid.
2. Approach left: self=6, opp=1, health 3/3, tick -> next cycle action=000, action_valid=1 for one cycle only, state_dbg=1. With self=1, opp=6 -> action=001.
3. Attack and cooldown: SEED=8'hA5, self=2, opp=1, health 3/3.
   - Tick 1 -> action=101 (KICK), state_dbg=2.
   - Ticks 2 and 3 -> state_dbg=3, action in {010, 011}.
   - Tick 4 -> state_dbg=2. Repeat tick 1 with SEED=8'hA4 -> action=100.
4. Low-health evade: health_self=1 during cooldown.
   - self=3, opp=2 -> action=001.
   - self=7, opp=6 -> action=010 (boundary).
   - self=4, opp=4 -> action=010 (dist 0).
5. Defeat: health_opp=0, tick -> action=011, state_dbg=4. Restore health_opp=3 and self=6, opp=1, tick -> stays 011/4. Pulse reset -> state_dbg=0.
6. Mid-operation reset: assert reset between clk edges during cooldown -> outputs go to reset values immediately. Next in-range tick after release -> ATTACK, since cooldown was cleared.
